// File: rtl/opcodes.sv
// Shared RV32I types, opcode constants and issue-stage state encoding.
package opcodes;

    localparam int unsigned REG_W    = 32;
    localparam int unsigned OPCODE_W = 7;

    typedef logic [REG_W-1:0] register_t;
    typedef logic [REG_W-1:0] instruction_t;

    localparam logic [OPCODE_W-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPCODE_W-1:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } issue_state_t;

    // Opcode field of an instruction word.
    function automatic logic [OPCODE_W-1:0] opcode_of(input instruction_t instr);
        return instr[OPCODE_W-1:0];
    endfunction

endpackage

// File: rtl/alu_imm_gen.sv
// Operand builder: picks register or immediate operands per opcode and
// flags whether the opcode is one the ALU supports.
module alu_imm_gen
    import opcodes::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] instr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic [XLEN-1:0] op1,
    output logic [XLEN-1:0] op2,
    output logic            supported
);

    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_u;

    // I-type sign-extended immediate; shift amounts keep the upper bits as-is.
    assign imm_i = XLEN'($signed(instr[31:20]));
    // U-type immediate placed in the upper 20 bits.
    assign imm_u = XLEN'({instr[31:12], 12'b0});

    // Operand selection by opcode.
    always_comb begin
        op1       = '0;
        op2       = '0;
        supported = 1'b0;
        case (instr[6:0])
            OPC_OP: begin
                op1       = rs1_data;
                op2       = rs2_data;
                supported = 1'b1;
            end
            OPC_OP_IMM: begin
                op1       = rs1_data;
                op2       = imm_i;
                supported = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                op1       = imm_u;
                op2       = '0;
                supported = 1'b1;
            end
            default: begin
                supported = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// Operand-fetch / issue stage in front of the registered RV32I ALU.
// One instruction in flight: IDLE -> READ -> EXEC -> WB, with a new
// instruction accepted in WB overlapping the write-back commit.
// Optional retire/illegal counters are built when ALU_ISSUE_COUNT_EN is defined.
module alu_issue
    import opcodes::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    in_instr,
    input  logic [XLEN-1:0]    in_pc,
    output logic [RADDR_W-1:0] rf_rs1_addr,
    output logic [RADDR_W-1:0] rf_rs2_addr,
    input  logic [XLEN-1:0]    rf_rs1_data,
    input  logic [XLEN-1:0]    rf_rs2_data,
    output logic [XLEN-1:0]    alu_instr,
    output logic [XLEN-1:0]    alu_op1,
    output logic [XLEN-1:0]    alu_op2,
    output logic [XLEN-1:0]    alu_pc,
    output logic               alu_enable,
    input  logic [XLEN-1:0]    alu_result,
    output logic               rf_we,
    output logic [RADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]    rf_wdata,
    output logic               illegal,
    output logic               busy
`ifdef ALU_ISSUE_COUNT_EN
    ,
    output logic [31:0]        retired_count,
    output logic [31:0]        illegal_count
`endif
);

    issue_state_t      state_q;
    issue_state_t      state_d;
    logic [XLEN-1:0]   instr_q;
    logic [XLEN-1:0]   pc_q;
    logic              accept;
    logic [XLEN-1:0]   gen_op1;
    logic [XLEN-1:0]   gen_op2;
    logic              gen_supported;
    logic              in_read;
    logic [RADDR_W-1:0] rd;

    assign in_ready = (state_q == IDLE) || (state_q == WB);
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q != IDLE);
    assign in_read  = (state_q == READ);
    assign rd       = RADDR_W'(instr_q[11:7]);

    // Register-file read addresses come from the captured instruction.
    assign rf_rs1_addr = RADDR_W'(instr_q[19:15]);
    assign rf_rs2_addr = RADDR_W'(instr_q[24:20]);

    // Write-back: ALU result is valid during WB; x0 writes are dropped.
    assign rf_we    = (state_q == WB) && (rd != '0);
    assign rf_waddr = rd;
    assign rf_wdata = alu_result;

    alu_imm_gen #(
        .XLEN(XLEN)
    ) u_imm_gen (
        .instr     (instr_q),
        .rs1_data  (rf_rs1_data),
        .rs2_data  (rf_rs2_data),
        .op1       (gen_op1),
        .op2       (gen_op2),
        .supported (gen_supported)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = READ;
                end
            end
            READ: begin
                state_d = gen_supported ? EXEC : IDLE;
            end
            EXEC: begin
                state_d = WB;
            end
            WB: begin
                state_d = accept ? READ : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Capture the accepted instruction and its PC.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_q <= '0;
            pc_q    <= '0;
        end else if (accept) begin
            instr_q <= in_instr;
            pc_q    <= in_pc;
        end
    end

    // ALU issue registers loaded at the end of READ; enable/illegal are one-cycle pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_instr  <= '0;
            alu_op1    <= '0;
            alu_op2    <= '0;
            alu_pc     <= '0;
            alu_enable <= 1'b0;
            illegal    <= 1'b0;
        end else begin
            alu_enable <= in_read && gen_supported;
            illegal    <= in_read && !gen_supported;
            if (in_read && gen_supported) begin
                alu_instr <= instr_q;
                alu_op1   <= gen_op1;
                alu_op2   <= gen_op2;
                alu_pc    <= pc_q;
            end
        end
    end

`ifdef ALU_ISSUE_COUNT_EN
    // Retired (every WB cycle) and illegal-pulse counters, wrapping at 2^32.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retired_count <= '0;
            illegal_count <= '0;
        end else begin
            if (state_q == WB) begin
                retired_count <= 32'(retired_count + 32'd1);
            end
            if (illegal) begin
                illegal_count <= 32'(illegal_count + 32'd1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: bench-side register file and
// registered ALU, an architectural model that predicts every ALU issue
// and register write, and directed instruction vectors.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [4:0]  rf_rs1_addr;
    logic [4:0]  rf_rs2_addr;
    logic [31:0] rf_rs1_data;
    logic [31:0] rf_rs2_data;
    logic [31:0] alu_instr;
    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic [31:0] alu_pc;
    logic        alu_enable;
    logic [31:0] alu_result = '0;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        illegal;
    logic        busy;
`ifdef ALU_ISSUE_COUNT_EN
    logic [31:0] retired_count;
    logic [31:0] illegal_count;
`endif

    alu_issue #(.XLEN(32), .RADDR_W(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .rf_rs1_addr (rf_rs1_addr),
        .rf_rs2_addr (rf_rs2_addr),
        .rf_rs1_data (rf_rs1_data),
        .rf_rs2_data (rf_rs2_data),
        .alu_instr   (alu_instr),
        .alu_op1     (alu_op1),
        .alu_op2     (alu_op2),
        .alu_pc      (alu_pc),
        .alu_enable  (alu_enable),
        .alu_result  (alu_result),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .illegal     (illegal),
        .busy        (busy)
`ifdef ALU_ISSUE_COUNT_EN
        ,
        .retired_count (retired_count),
        .illegal_count (illegal_count)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- bench environment: register file and ALU ----------------
    logic [31:0] rf [32] = '{default: '0};
    assign rf_rs1_data = rf[rf_rs1_addr];
    assign rf_rs2_data = rf[rf_rs2_addr];

    always @(posedge clk) begin
        if (rf_we) rf[rf_waddr] <= rf_wdata;
    end

    // RV32I ALU semantics for the supported opcode classes.
    function automatic logic [31:0] rv_alu(input logic [31:0] instr, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] pc);
        logic [6:0] opc;
        logic [2:0] f3;
        opc = instr[6:0];
        f3  = instr[14:12];
        if (opc == 7'b0110111) return a + b;
        if (opc == 7'b0010111) return pc + a;
        case (f3)
            3'd0: return (opc == 7'b0110011 && instr[30]) ? a - b : a + b;
            3'd1: return a << b[4:0];
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return instr[30] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    always @(posedge clk) begin
        if (alu_enable) alu_result <= rv_alu(alu_instr, alu_op1, alu_op2, alu_pc);
    end

    // ---------------- architectural model and scoreboard ----------------
    typedef struct {
        logic [31:0] instr;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] pc;
        logic        chk_pc;
    } iss_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    iss_t        iss_q[$];
    wb_t         wb_q[$];
    int          ill_pending = 0;
    logic [31:0] arch [32] = '{default: '0};
    int          exp_retired = 0;
    int          exp_illegal = 0;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic fail_event(input string name);
        total++;
        bad++;
        $display("FAIL %s: event seen, none expected", name);
    endtask

    // Predict the ALU issue and write-back of an accepted instruction from ISA rules.
    task automatic model_accept(input logic [31:0] instr, input logic [31:0] pc);
        iss_t        e;
        wb_t         w;
        logic [6:0]  opc;
        logic [31:0] res;
        opc = instr[6:0];
        e.instr  = instr;
        e.pc     = pc;
        e.chk_pc = 1'b0;
        case (opc)
            7'b0110011: begin e.op1 = arch[instr[19:15]]; e.op2 = arch[instr[24:20]]; end
            7'b0010011: begin e.op1 = arch[instr[19:15]]; e.op2 = {{20{instr[31]}}, instr[31:20]}; end
            7'b0110111: begin e.op1 = {instr[31:12], 12'h000}; e.op2 = 32'd0; end
            7'b0010111: begin e.op1 = {instr[31:12], 12'h000}; e.op2 = 32'd0; e.chk_pc = 1'b1; end
            default: begin
                ill_pending++;
                exp_illegal++;
                return;
            end
        endcase
        res = rv_alu(instr, e.op1, e.op2, pc);
        iss_q.push_back(e);
        exp_retired++;
        if (instr[11:7] != 5'd0) begin
            w.rd   = instr[11:7];
            w.data = res;
            wb_q.push_back(w);
            arch[instr[11:7]] = res;
        end
    endtask

    // Compare process: every ALU issue, register write and illegal pulse must be predicted.
    always @(negedge clk) begin
        if (rst) begin
            if (alu_enable) begin
                if (iss_q.size() == 0) fail_event("alu_enable");
                else begin
                    iss_t e;
                    e = iss_q.pop_front();
                    check("alu_instr", alu_instr, e.instr);
                    check("alu_op1", alu_op1, e.op1);
                    check("alu_op2", alu_op2, e.op2);
                    if (e.chk_pc) check("alu_pc", alu_pc, e.pc);
                end
            end
            if (rf_we) begin
                if (wb_q.size() == 0) fail_event("rf_we");
                else begin
                    wb_t w;
                    w = wb_q.pop_front();
                    check("rf_waddr", 32'(rf_waddr), 32'(w.rd));
                    check("rf_wdata", rf_wdata, w.data);
                end
            end
            if (illegal) begin
                if (ill_pending == 0) fail_event("illegal");
                else ill_pending--;
            end
        end
    end

    // ---------------- stimulus ----------------
    int last_accept = 0;
    int accept_gap  = 0;

    task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
        int n = 0;
        @(negedge clk); #1;
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        while (!in_ready && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            fail_event("accept_timeout");
            in_valid = 1'b0;
            return;
        end
        model_accept(instr, pc);
        accept_gap  = cyc - last_accept;
        last_accept = cyc;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || iss_q.size() != 0 || wb_q.size() != 0 || ill_pending != 0) && n < 30) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= 30) fail_event("idle_timeout");
    endtask

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        in_instr = '0;
        in_pc    = '0;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_alu_enable", 32'(alu_enable), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_rf_we", 32'(rf_we), 32'd0);
        check("rst_alu_op1", alu_op1, 32'd0);
        check("rst_alu_op2", alu_op2, 32'd0);
        check("rst_alu_pc", alu_pc, 32'd0);
        check("rst_alu_instr", alu_instr, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // ADDI then back-to-back ADD accepted in WB
        issue(32'h00500093, 32'h0);
        issue(32'h00108133, 32'h4);
        check("b2b_accept_gap", 32'(accept_gap), 32'd3);
        issue(32'h123451B7, 32'h8);   // LUI x3,0x12345
        issue(32'h00001217, 32'h100); // AUIPC x4,1
        issue(32'h00100013, 32'h104); // ADDI x0,x0,1
        issue(32'h40100433, 32'h108); // SUB x8,x0,x1
        issue(32'h4041D393, 32'h10C); // SRAI x7,x3,4
        issue(32'hFFFFFFFF, 32'h110); // unsupported
        wait_idle();
        check("post_illegal_ready", 32'(in_ready), 32'd1);
        check("post_illegal_busy", 32'(busy), 32'd0);
        check("x0", rf[0], 32'h0);
        check("x1", rf[1], 32'h5);
        check("x2", rf[2], 32'hA);
        check("x3", rf[3], 32'h12345000);
        check("x4", rf[4], 32'h1100);
        check("x7", rf[7], 32'h01234500);
        check("x8", rf[8], 32'hFFFFFFFB);
`ifdef ALU_ISSUE_COUNT_EN
        check("retired_count_a", retired_count, 32'(exp_retired));
        check("illegal_count_a", illegal_count, 32'(exp_illegal));
`endif

        // Asynchronous reset while the ALU is enabled
        issue(32'h00700293, 32'h200); // ADDI x5,x0,7
        begin
            int n = 0;
            while (!alu_enable && n < 10) begin
                @(negedge clk); #1;
                n++;
            end
            if (!alu_enable) fail_event("exec_timeout");
        end
        rst = 1'b0;
        #1;
        check("mid_rst_alu_enable", 32'(alu_enable), 32'd0);
        check("mid_rst_alu_op1", alu_op1, 32'd0);
        check("mid_rst_alu_op2", alu_op2, 32'd0);
        check("mid_rst_alu_instr", alu_instr, 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_rf_we", 32'(rf_we), 32'd0);
        iss_q.delete();
        wb_q.delete();
        ill_pending = 0;
        exp_retired = 0;
        exp_illegal = 0;
        for (int i = 0; i < 32; i++) arch[i] = rf[i];
        @(negedge clk);
        @(negedge clk); #2;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("post_rst_ready", 32'(in_ready), 32'd1);
        check("x5_abandoned", rf[5], 32'h0);

        issue(32'h00900313, 32'h300); // ADDI x6,x0,9
        issue(32'hABCDE4B7, 32'h304); // LUI x9,0xABCDE
        issue(32'h00930533, 32'h308); // ADD x10,x6,x9
        issue(32'h0000000F, 32'h30C); // FENCE: unsupported here
        wait_idle();
        check("x6", rf[6], 32'h9);
        check("x9", rf[9], 32'hABCDE000);
        check("x10", rf[10], 32'hABCDE009);
`ifdef ALU_ISSUE_COUNT_EN
        check("retired_count_b", retired_count, 32'd3);
        check("illegal_count_b", illegal_count, 32'd1);
`endif
        check("end_iss_q_empty", 32'(iss_q.size()), 32'd0);
        check("end_wb_q_empty", 32'(wb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
